// File: rtl/huffman_pkg.sv
// huffman_pkg: shared sizing defaults and decoder state type for the Huffman decode path
package huffman_pkg;
  localparam int DATA_WIDTH    = 8;
  localparam int TOTAL_SYMBOLS = 10;
  localparam int ADDR_WIDTH    = 4;
  localparam int MAX_CODE_LEN  = 16;
  localparam int LEN_WIDTH     = 5;
  typedef enum logic {COLLECT, OUTPUT} state_t;
endpackage

// File: rtl/huffman_code_match.sv
// huffman_code_match: one code-table entry and its match line against the bit accumulator
module huffman_code_match #(
  parameter int MAX_CODE_LEN = huffman_pkg::MAX_CODE_LEN,
  parameter int LEN_WIDTH    = huffman_pkg::LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [MAX_CODE_LEN-1:0] code,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [MAX_CODE_LEN-1:0] acc,
  input  logic [LEN_WIDTH-1:0]    cnt,
  output logic                    match
);
  logic [MAX_CODE_LEN-1:0] code_q, mask;
  logic [LEN_WIDTH-1:0]    len_q;
  // entry storage, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
      len_q  <= '0;
    end else if (we) begin
      code_q <= code;
      len_q  <= len;
    end
  end
  // only the low len bits of the code take part in the compare
  always_comb begin
    mask = '0;
    for (int k = 0; k < MAX_CODE_LEN; k++) mask[k] = k < int'(len_q);
  end
  assign match = (cnt != '0) && (len_q == cnt) && (((code_q ^ acc) & mask) == '0);
endmodule

// File: rtl/huffman_decoder.sv
// huffman_decoder: bit-serial Huffman decoder with loadable code table and symbol handshake
module huffman_decoder #(
  parameter int TOTAL_SYMBOLS = huffman_pkg::TOTAL_SYMBOLS,
  parameter int ADDR_WIDTH    = huffman_pkg::ADDR_WIDTH,
  parameter int MAX_CODE_LEN  = huffman_pkg::MAX_CODE_LEN,
  parameter int LEN_WIDTH     = huffman_pkg::LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tbl_we,
  input  logic [ADDR_WIDTH-1:0]   tbl_addr,
  input  logic [MAX_CODE_LEN-1:0] tbl_code,
  input  logic [LEN_WIDTH-1:0]    tbl_len,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic [ADDR_WIDTH-1:0]   sym_out,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    err
);
  import huffman_pkg::*;
  logic [MAX_CODE_LEN-1:0]  acc;
  logic [LEN_WIDTH-1:0]     cnt;
  logic [TOTAL_SYMBOLS-1:0] hit;
  logic [ADDR_WIDTH-1:0]    sel;
  logic                     any, full;
  state_t                   state;
  for (genvar i = 0; i < TOTAL_SYMBOLS; i++) begin : g_entry
    huffman_code_match #(.MAX_CODE_LEN(MAX_CODE_LEN), .LEN_WIDTH(LEN_WIDTH)) u_match (
      .clk  (clk),
      .rst  (rst),
      .we   (tbl_we && tbl_addr == ADDR_WIDTH'(i)),
      .code (tbl_code),
      .len  (tbl_len),
      .acc  (acc),
      .cnt  (cnt),
      .match(hit[i])
    );
  end
  // lowest matching index wins
  always_comb begin
    sel = '0;
    for (int k = TOTAL_SYMBOLS - 1; k >= 0; k--) if (hit[k]) sel = ADDR_WIDTH'(k);
  end
  assign any       = |hit;
  assign full      = cnt == LEN_WIDTH'(MAX_CODE_LEN);
  assign bit_ready = (state == COLLECT) && !any && !full;
  // collect bits, emit a symbol on match, flag and flush an unmatched full accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      sym_out   <= '0;
      sym_valid <= 1'b0;
      err       <= 1'b0;
      state     <= COLLECT;
    end else begin
      err <= 1'b0;
      if (state == OUTPUT) begin
        if (sym_ready) begin
          sym_valid <= 1'b0;
          state     <= COLLECT;
        end
      end else if (any) begin
        sym_out   <= sel;
        sym_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        state     <= OUTPUT;
      end else if (full) begin
        err <= 1'b1;
        acc <= '0;
        cnt <= '0;
      end else if (bit_valid) begin
        acc <= {acc[MAX_CODE_LEN-2:0], bit_in};
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_huffman_decoder.sv
// tb_huffman_decoder: directed and randomized checks against a table-driven decode model
module tb_huffman_decoder;
  logic        clk = 0, rst = 1, tbl_we = 0, bit_in = 0, bit_valid = 0, sym_ready = 1;
  logic [3:0]  tbl_addr = 0;
  logic [15:0] tbl_code = 0;
  logic [4:0]  tbl_len = 0;
  logic        bit_ready, sym_valid, err;
  logic [3:0]  sym_out;
  int total = 0, bad = 0, cyc = 0;
  int mcode[10], mlen[10];
  int got[$], exp[$], acc_cyc[$];
  bit hist[$], pend[$];

  huffman_decoder dut (
    .clk(clk), .rst(rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_code(tbl_code),
    .tbl_len(tbl_len), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (sym_valid && sym_ready) got.push_back(int'(sym_out));
    if (err) got.push_back(-1);
  end

  task automatic clear_model();
    for (int i = 0; i < 10; i++) begin
      mcode[i] = 0;
      mlen[i] = 0;
    end
    hist.delete();
    pend.delete();
    got.delete();
    acc_cyc.delete();
  endtask

  task automatic do_reset();
    rst = 1;
    bit_valid = 0;
    tbl_we = 0;
    sym_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    clear_model();
  endtask

  task automatic wr(input int a, input int code, input int len);
    tbl_we = 1;
    tbl_addr = a[3:0];
    tbl_code = code[15:0];
    tbl_len = len[4:0];
    @(posedge clk);
    #1 tbl_we = 0;
    if (a < 10) begin
      mcode[a] = code & 16'hffff;
      mlen[a] = len;
    end
  endtask

  task automatic load_basic();
    wr(0, 0, 1);
    wr(1, 2, 2);
    wr(2, 6, 3);
    wr(3, 7, 3);
  endtask

  task automatic add(input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      pend.push_back(v[k]);
      hist.push_back(v[k]);
    end
  endtask

  task automatic send();
    int i = 0, g = 0;
    bit a;
    while (i < pend.size() && g < 2000) begin
      bit_valid = 1;
      bit_in = pend[i];
      @(negedge clk);
      a = bit_ready;
      if (a) acc_cyc.push_back(cyc);
      @(posedge clk);
      #1;
      if (a) i++;
      g++;
    end
    bit_valid = 0;
    if (i < pend.size()) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=%0d bits need=%0d", i, pend.size());
    end
    pend.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // reference: walk the whole bit history, resolving codewords from the table rules
  task automatic model();
    int n = 0, v = 0, hit;
    exp.delete();
    foreach (hist[k]) begin
      v = (v << 1) | int'(hist[k]);
      n++;
      hit = -1;
      for (int i = 0; i < 10; i++)
        if (hit < 0 && mlen[i] == n && ((mcode[i] ^ v) & ((1 << n) - 1)) == 0) hit = i;
      if (hit >= 0 || n == 16) begin
        exp.push_back(hit);
        n = 0;
        v = 0;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total += 4;
    if (bit_ready !== 1'b1) begin bad++; $display("FAIL reset_bit_ready got=%b need=1", bit_ready); end
    if (sym_valid !== 1'b0) begin bad++; $display("FAIL reset_sym_valid got=%b need=0", sym_valid); end
    if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b need=0", err); end
    if (sym_out !== 4'd0) begin bad++; $display("FAIL reset_sym_out got=%0d need=0", sym_out); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    load_basic();
    add(0, 1);
    send();
    @(negedge clk);
    total += 2;
    if (bit_ready !== 1'b0) begin bad++; $display("FAIL single_match_ready got=%b need=0", bit_ready); end
    if (sym_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid got=%b need=0", sym_valid); end
    @(posedge clk);
    @(negedge clk);
    total += 2;
    if (sym_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b need=1", sym_valid); end
    if (sym_out !== 4'd0) begin bad++; $display("FAIL single_sym got=%0d need=0", sym_out); end
    idle(3);
    model();
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL single_count got=%0d need=%0d", got.size(), exp.size()); end
    else foreach (exp[k]) begin total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL single_sym%0d got=%0d need=%0d", k, got[k], exp[k]); end end
  endtask

  task automatic test_back_to_back();
    int gap[4] = '{1, 1, 3, 1};
    do_reset();
    load_basic();
    add(5'b11010, 5);
    send();
    idle(4);
    model();
    total++;
    if (got.size() != 2 || exp.size() != 2) begin bad++; $display("FAIL b2b_count got=%0d need=%0d", got.size(), exp.size()); end
    else foreach (exp[k]) begin total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL b2b_sym%0d got=%0d need=%0d", k, got[k], exp[k]); end end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (acc_cyc[k+1] - acc_cyc[k] != gap[k]) begin bad++; $display("FAIL b2b_gap%0d got=%0d need=%0d", k, acc_cyc[k+1] - acc_cyc[k], gap[k]); end
    end
  endtask

  task automatic test_hold();
    do_reset();
    load_basic();
    sym_ready = 0;
    add(3'b111, 3);
    send();
    idle(1);
    repeat (5) begin
      @(negedge clk);
      total++;
      if (sym_valid !== 1'b1 || sym_out !== 4'd3 || bit_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold got=v%b s%0d r%b need=v1 s3 r0", sym_valid, sym_out, bit_ready);
      end
      @(posedge clk);
      #1;
    end
    sym_ready = 1;
    idle(1);
    add(0, 1);
    send();
    idle(4);
    model();
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL hold_count got=%0d need=%0d", got.size(), exp.size()); end
    else foreach (exp[k]) begin total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL hold_sym%0d got=%0d need=%0d", k, got[k], exp[k]); end end
  endtask

  task automatic test_error();
    do_reset();
    wr(0, 5, 3);
    add(16'hffff, 16);
    send();
    @(negedge clk);
    total++;
    if (bit_ready !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL err_n1 got=r%b e%b need=r0 e0", bit_ready, err); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bit_ready !== 1'b1 || err !== 1'b1) begin bad++; $display("FAIL err_n2 got=r%b e%b need=r1 e1", bit_ready, err); end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL err_pulse got=%b need=0", err); end
    @(posedge clk);
    #1;
    add(3'b101, 3);
    send();
    idle(4);
    model();
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL err_count got=%0d need=%0d", got.size(), exp.size()); end
    else foreach (exp[k]) begin total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL err_sym%0d got=%0d need=%0d", k, got[k], exp[k]); end end
  endtask

  task automatic test_priority();
    do_reset();
    wr(7, 1, 2);
    wr(4, 1, 2);
    add(2'b01, 2);
    send();
    idle(4);
    total++;
    if (got.size() != 1 || got[0] !== 4) begin bad++; $display("FAIL priority got=%p need='{4}", got); end
  endtask

  task automatic test_rst();
    do_reset();
    load_basic();
    add(2'b11, 2);
    send();
    rst = 1;
    #1;
    total++;
    if (bit_ready !== 1'b1 || sym_valid !== 1'b0 || err !== 1'b0 || sym_out !== 4'd0) begin
      bad++;
      $display("FAIL rst_mid_code got=r%b v%b e%b s%0d need=r1 v0 e0 s0", bit_ready, sym_valid, err, sym_out);
    end
    idle(1);
    rst = 0;
    clear_model();
    load_basic();
    sym_ready = 0;
    add(0, 1);
    send();
    idle(2);
    rst = 1;
    #1;
    total++;
    if (sym_valid !== 1'b0 || bit_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_out got=v%b r%b need=v0 r1", sym_valid, bit_ready); end
    idle(1);
    rst = 0;
    sym_ready = 1;
    clear_model();
    add(4'b0110, 4);
    send();
    idle(4);
    total++;
    if (got.size() != 0 || bit_ready !== 1'b1) begin bad++; $display("FAIL rst_cleared got=%0d outputs r%b need=0 outputs r1", got.size(), bit_ready); end
    add(12'hfff, 12);
    send();
    idle(4);
    model();
    total++;
    if (got.size() != exp.size()) begin bad++; $display("FAIL rst_err_count got=%0d need=%0d", got.size(), exp.size()); end
    else foreach (exp[k]) begin total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL rst_err%0d got=%0d need=%0d", k, got[k], exp[k]); end end
  endtask

  task automatic test_random();
    bit done;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 10; i++) wr(i, int'($urandom_range(0, 65535)), int'($urandom_range(0, 4)));
      wr(9, 0, 20);
      wr(12, 0, 1);
      for (int k = 0; k < 150; k++) add(32'($urandom_range(0, 1)), 1);
      done = 0;
      fork
        begin
          send();
          done = 1;
        end
        while (!done) begin
          @(posedge clk);
          #1 sym_ready = 1'($urandom_range(0, 1));
        end
      join
      sym_ready = 1;
      idle(40);
      model();
      total++;
      if (got.size() != exp.size()) begin bad++; $display("FAIL rand%0d_count got=%0d need=%0d", r, got.size(), exp.size()); end
      else foreach (exp[k]) begin total++; if (got[k] !== exp[k]) begin bad++; $display("FAIL rand%0d_sym%0d got=%0d need=%0d", r, k, got[k], exp[k]); end end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_error();
    test_priority();
    test_rst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
